// File: rtl/rx_pb_sched_pkg.sv
// Shared encodings and constants for the RX PB frame sequencer.
package rx_pb_sched_pkg;

  localparam int unsigned LEN16  = 64;
  localparam int unsigned LEN136 = 544;
  localparam int unsigned LEN520 = 2080;
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned PBN_W  = 8;
  localparam int unsigned TO_CYC = 8192;
  localparam int unsigned WD_W   = $clog2(TO_CYC);

  typedef enum logic [1:0] {
    PB16   = 2'b00,
    PB136  = 2'b01,
    PB520  = 2'b10,
    PB_RSV = 2'b11
  } pb_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_GAP   = 2'b11
  } state_e;

  // Symbols per PB for a size code; the reserved code never reaches this mux.
  function automatic logic [CNT_W-1:0] pb_len(input pb_size_e sz);
    case (sz)
      PB16:    return CNT_W'(LEN16);
      PB136:   return CNT_W'(LEN136);
      default: return CNT_W'(LEN520);
    endcase
  endfunction

endpackage

// File: rtl/rx_pb_sched_wdog.sv
// Loadable down-counter; expire_c is high while enabled and the count has run out.
module rx_pb_sched_wdog
  import rx_pb_sched_pkg::*;
(
  input  logic            clk,
  input  logic            n_rst,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [WD_W-1:0] val_i,
  output logic            expire_c
);

  logic [WD_W-1:0] cnt_q, cnt_d;

  // Reload takes precedence; counting stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WD_W'(1);
    end
  end

  assign expire_c = en_i && (cnt_q == '0);

  // Count register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_pb_sched.sv
// Frame-level sequencer: loads one PB of symbols into the deinterleaver core,
// waits for the core to stream it out, and repeats for every PB of the frame.
module rx_pb_sched
  import rx_pb_sched_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             frm_start,
  input  logic [1:0]       frm_pb_size,
  input  logic [PBN_W-1:0] frm_pb_num,
  input  logic             abort,
  input  logic [1:0]       in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [1:0]       core_pb_size,
  output logic [1:0]       core_din,
  output logic             core_din_vld,
  input  logic             core_dout_vld,
  output logic             pb_done,
  output logic             frm_done,
  output logic             busy,
  output logic             err
);

  state_e           state_q, state_d;
  pb_size_e         size_q, size_d;
  logic [PBN_W-1:0] num_q, num_d;
  logic [PBN_W-1:0] pb_cnt_q, pb_cnt_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             ovf_q, ovf_d;
  logic             dvld_prev_q;
  logic             in_rdy_q, in_rdy_d;
  logic [1:0]       din_q, din_d;
  logic             din_vld_q, din_vld_d;
  logic             pb_done_q, pb_done_d;
  logic             frm_done_q, frm_done_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] len_c;
  logic             fall_c;
  logic             wd_expire_c;

  assign len_c  = pb_len(size_q);
  assign fall_c = dvld_prev_q & ~core_dout_vld;

  // Watchdog is held loaded through LOAD and runs only in DRAIN.
  rx_pb_sched_wdog u_wdog (
    .clk      (clk),
    .n_rst    (n_rst),
    .load_i   (state_q == ST_LOAD),
    .en_i     (state_q == ST_DRAIN),
    .val_i    (WD_W'(TO_CYC - 1)),
    .expire_c (wd_expire_c)
  );

  // Next-state, counters and registered output values.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    num_d      = num_q;
    pb_cnt_d   = pb_cnt_q;
    sym_cnt_d  = sym_cnt_q;
    out_cnt_d  = out_cnt_q;
    ovf_d      = ovf_q;
    din_d      = din_q;
    din_vld_d  = 1'b0;
    pb_done_d  = 1'b0;
    frm_done_d = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frm_start) begin
          if ((frm_pb_size != PB_RSV) && (frm_pb_num != '0)) begin
            size_d    = pb_size_e'(frm_pb_size);
            num_d     = frm_pb_num;
            pb_cnt_d  = '0;
            sym_cnt_d = '0;
            out_cnt_d = '0;
            ovf_d     = 1'b0;
            state_d   = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (in_vld && in_rdy_q) begin
          din_d     = in_data;
          din_vld_d = 1'b1;
          if (sym_cnt_q == (len_c - CNT_W'(1))) begin
            sym_cnt_d = '0;
            out_cnt_d = '0;
            ovf_d     = 1'b0;
            state_d   = ST_DRAIN;
          end else begin
            sym_cnt_d = sym_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Saturate at LEN and remember an overlong burst instead of wrapping.
        if (core_dout_vld) begin
          if (out_cnt_q == len_c) begin
            ovf_d = 1'b1;
          end else begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
          end
        end
        if (fall_c) begin
          if ((out_cnt_q == len_c) && !ovf_q) begin
            pb_done_d = 1'b1;
            pb_cnt_d  = pb_cnt_q + PBN_W'(1);
            if (pb_cnt_q == (num_q - PBN_W'(1))) begin
              frm_done_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (wd_expire_c) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        sym_cnt_d = '0;
        out_cnt_d = '0;
        ovf_d     = 1'b0;
        state_d   = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      err_d      = 1'b1;
      din_vld_d  = 1'b0;
      pb_done_d  = 1'b0;
      frm_done_d = 1'b0;
    end

    in_rdy_d = (state_d == ST_LOAD);
    busy_d   = (state_d != ST_IDLE);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      size_q      <= PB16;
      num_q       <= '0;
      pb_cnt_q    <= '0;
      sym_cnt_q   <= '0;
      out_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      dvld_prev_q <= 1'b0;
      in_rdy_q    <= 1'b0;
      din_q       <= '0;
      din_vld_q   <= 1'b0;
      pb_done_q   <= 1'b0;
      frm_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      num_q       <= num_d;
      pb_cnt_q    <= pb_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      out_cnt_q   <= out_cnt_d;
      ovf_q       <= ovf_d;
      dvld_prev_q <= core_dout_vld;
      in_rdy_q    <= in_rdy_d;
      din_q       <= din_d;
      din_vld_q   <= din_vld_d;
      pb_done_q   <= pb_done_d;
      frm_done_q  <= frm_done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign in_rdy       = in_rdy_q;
  assign core_pb_size = size_q;
  assign core_din     = din_q;
  assign core_din_vld = din_vld_q;
  assign pb_done      = pb_done_q;
  assign frm_done     = frm_done_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: tb/tb_rx_pb_sched.sv
// Directed bench for rx_pb_sched with a stub core driven from the tasks.
module tb_rx_pb_sched;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       frm_start;
  logic [1:0] frm_pb_size;
  logic [7:0] frm_pb_num;
  logic       abort;
  logic [1:0] in_data;
  logic       in_vld;
  logic       in_rdy;
  logic [1:0] core_pb_size;
  logic [1:0] core_din;
  logic       core_din_vld;
  logic       core_dout_vld;
  logic       pb_done;
  logic       frm_done;
  logic       busy;
  logic       err;

  int errors = 0;
  int checks = 0;
  int din_cnt = 0, din_bad = 0, pb_seen = 0, frm_seen = 0, err_seen = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_exp;

  rx_pb_sched dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .frm_start     (frm_start),
    .frm_pb_size   (frm_pb_size),
    .frm_pb_num    (frm_pb_num),
    .abort         (abort),
    .in_data       (in_data),
    .in_vld        (in_vld),
    .in_rdy        (in_rdy),
    .core_pb_size  (core_pb_size),
    .core_din      (core_din),
    .core_din_vld  (core_din_vld),
    .core_dout_vld (core_dout_vld),
    .pb_done       (pb_done),
    .frm_done      (frm_done),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Output monitor: every core_din beat must be the next accepted symbol.
  always @(posedge clk) begin
    #1;
    if (core_din_vld) begin
      din_cnt++;
      if (exp_q.size() == 0) begin
        din_bad++;
      end else begin
        mon_exp = exp_q.pop_front();
        if (core_din !== mon_exp) din_bad++;
      end
    end
    if (pb_done)  pb_seen++;
    if (frm_done) frm_seen++;
    if (err)      err_seen++;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  task automatic start_frame(input logic [1:0] sz, input logic [7:0] num);
    frm_start = 1'b1; frm_pb_size = sz; frm_pb_num = num;
    @(negedge clk);
    frm_start = 1'b0;
  endtask

  // Offers symbols with pct% in_vld density until n are accepted (bounded).
  task automatic load_pb(input int n, input int pct, input bit hold);
    int acc = 0;
    int cyc = 0;
    logic r;
    while (acc < n && cyc < 20000) begin
      in_vld  = ($urandom_range(99) < pct);
      in_data = 2'($urandom);
      r = in_rdy;
      @(posedge clk);
      if (in_vld && r) begin
        exp_q.push_back(in_data);
        acc++;
      end
      cyc++;
      @(negedge clk);
    end
    if (!hold) in_vld = 1'b0;
    checks++;
    if (acc != n) begin
      errors++;
      $display("FAIL load_accept: accepted %0d, required %0d", acc, n);
    end
  endtask

  // Stub core readout: dout_vld high for n cycles; returns where pb_done is due.
  task automatic readout(input int n);
    @(negedge clk);
    core_dout_vld = 1'b1;
    repeat (n) @(negedge clk);
    core_dout_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    n_rst = 1'b0; frm_start = 1'b0; frm_pb_size = 2'b00; frm_pb_num = 8'd0;
    abort = 1'b0; in_data = 2'b00; in_vld = 1'b0; core_dout_vld = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_rdy, core_pb_size, core_din, core_din_vld, pb_done, frm_done, busy, err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {in_rdy, core_pb_size, core_din, core_din_vld, pb_done, frm_done, busy, err});
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pb16;
    int d0 = din_cnt;
    int p0 = pb_seen;
    int f0 = frm_seen;
    start_frame(2'b00, 8'd1);
    checks++;
    if ({busy, in_rdy, core_pb_size} !== 4'b1100) begin
      errors++; $display("FAIL pb16_start: busy/rdy/size=%b required 1100", {busy, in_rdy, core_pb_size});
    end
    load_pb(64, 100, 1'b0);
    checks++;
    if (in_rdy !== 1'b0 || din_cnt - d0 != 64 || din_bad != 0) begin
      errors++; $display("FAIL pb16_load: rdy=%b beats=%0d bad=%0d required 0/64/0", in_rdy, din_cnt - d0, din_bad);
    end
    repeat (3) @(negedge clk);
    readout(64);
    checks++;
    if ({pb_done, frm_done, busy, err} !== 4'b1100) begin
      errors++; $display("FAIL pb16_done: pb/frm/busy/err=%b required 1100", {pb_done, frm_done, busy, err});
    end
    @(negedge clk);
    checks++;
    if (pb_done !== 1'b0 || pb_seen - p0 != 1 || frm_seen - f0 != 1) begin
      errors++; $display("FAIL pb16_pulse: pb=%b pb_cnt=%0d frm_cnt=%0d required 0/1/1", pb_done, pb_seen - p0, frm_seen - f0);
    end
  endtask

  task automatic test_pb136_multi;
    int d0 = din_cnt;
    int p0 = pb_seen;
    start_frame(2'b01, 8'd3);
    for (int p = 0; p < 3; p++) begin
      load_pb(544, 50, 1'b0);
      repeat (2) @(negedge clk);
      readout(544);
      checks++;
      if ({pb_done, frm_done, in_rdy, busy} !== {1'b1, p == 2, 1'b0, p != 2}) begin
        errors++; $display("FAIL pb136_pb%0d: pb/frm/rdy/busy=%b required %b", p,
                           {pb_done, frm_done, in_rdy, busy}, {1'b1, p == 2, 1'b0, p != 2});
      end
      if (p < 2) begin
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1) begin
          errors++; $display("FAIL pb136_gap%0d: in_rdy=%b after one gap cycle, required 1", p, in_rdy);
        end
      end
    end
    checks++;
    if (din_cnt - d0 != 1632 || pb_seen - p0 != 3 || din_bad != 0) begin
      errors++; $display("FAIL pb136_total: beats=%0d pbs=%0d bad=%0d required 1632/3/0", din_cnt - d0, pb_seen - p0, din_bad);
    end
  endtask

  task automatic test_pb520_backpressure;
    int d0 = din_cnt;
    int e0 = err_seen;
    start_frame(2'b10, 8'd2);
    load_pb(2080, 100, 1'b1);
    repeat (4) @(negedge clk);
    start_frame(2'b11, 8'd0);
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b0 || busy !== 1'b1 || din_cnt - d0 != 2080 || err_seen != e0 || core_pb_size !== 2'b10) begin
      errors++; $display("FAIL pb520_hold: rdy=%b busy=%b beats=%0d errs=%0d size=%b required 0/1/2080/0/10",
                         in_rdy, busy, din_cnt - d0, err_seen - e0, core_pb_size);
    end
    readout(2080);
    checks++;
    if ({pb_done, frm_done} !== 2'b10 || din_cnt - d0 != 2080) begin
      errors++; $display("FAIL pb520_pb0: pb/frm=%b beats=%0d required 10/2080", {pb_done, frm_done}, din_cnt - d0);
    end
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b1 || din_cnt - d0 != 2080) begin
      errors++; $display("FAIL pb520_gap: rdy=%b beats=%0d required 1/2080", in_rdy, din_cnt - d0);
    end
    load_pb(2080, 100, 1'b0);
    repeat (2) @(negedge clk);
    readout(2080);
    checks++;
    if ({pb_done, frm_done, busy} !== 3'b110 || din_cnt - d0 != 4160 || din_bad != 0) begin
      errors++; $display("FAIL pb520_end: pb/frm/busy=%b beats=%0d bad=%0d required 110/4160/0",
                         {pb_done, frm_done, busy}, din_cnt - d0, din_bad);
    end
  endtask

  task automatic test_bad_cfg;
    int e0 = err_seen;
    start_frame(2'b11, 8'd5);
    checks++;
    if ({err, busy, in_rdy} !== 3'b100) begin
      errors++; $display("FAIL badcfg_size: err/busy/rdy=%b required 100", {err, busy, in_rdy});
    end
    @(negedge clk);
    start_frame(2'b01, 8'd0);
    checks++;
    if ({err, busy, in_rdy} !== 3'b100) begin
      errors++; $display("FAIL badcfg_num: err/busy/rdy=%b required 100", {err, busy, in_rdy});
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || err_seen - e0 != 2) begin
      errors++; $display("FAIL badcfg_pulse: err=%b busy=%b pulses=%0d required 0/0/2", err, busy, err_seen - e0);
    end
  endtask

  task automatic test_timeout;
    int n = 0;
    int p0 = pb_seen;
    start_frame(2'b00, 8'd1);
    load_pb(64, 100, 1'b0);
    while (err !== 1'b1 && n < 9000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 8192 || busy !== 1'b0 || pb_seen != p0) begin
      errors++; $display("FAIL timeout: err after %0d cycles busy=%b pbs=%0d required 8192/0/0", n, busy, pb_seen - p0);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: err=%b busy=%b required 0/0", err, busy);
    end
  endtask

  task automatic test_abort_reset;
    int d0 = din_cnt;
    int p0 = pb_seen;
    start_frame(2'b01, 8'd2);
    load_pb(100, 100, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, err, in_rdy, core_din_vld, pb_done} !== 5'b01000 || din_cnt - d0 != 100) begin
      errors++; $display("FAIL abort: busy/err/rdy/dvld/pb=%b beats=%0d required 01000/100",
                         {busy, err, in_rdy, core_din_vld, pb_done}, din_cnt - d0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pb_seen != p0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL abort_after: pbs=%0d busy=%b err=%b required 0/0/0", pb_seen - p0, busy, err);
    end
    start_frame(2'b01, 8'd1);
    load_pb(544, 100, 1'b0);
    @(negedge clk);
    core_dout_vld = 1'b1;
    repeat (10) @(negedge clk);
    n_rst = 1'b0;
    #1;
    checks++;
    if ({in_rdy, core_pb_size, core_din, core_din_vld, pb_done, frm_done, busy, err} !== 11'd0) begin
      errors++; $display("FAIL reset_drain: outputs %b required all zero",
                         {in_rdy, core_pb_size, core_din, core_din_vld, pb_done, frm_done, busy, err});
    end
    @(negedge clk);
    core_dout_vld = 1'b0;
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pb_done !== 1'b0 || err !== 1'b0 || exp_q.size() != 0 || din_bad != 0) begin
      errors++; $display("FAIL reset_after: busy=%b pb=%b err=%b pending=%0d bad=%0d required 0/0/0/0/0",
                         busy, pb_done, err, exp_q.size(), din_bad);
    end
  endtask

  initial begin
    test_reset();
    test_pb16();
    test_pb136_multi();
    test_pb520_backpressure();
    test_bad_cfg();
    test_timeout();
    test_abort_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
